mod8_seq_checker: RTL and testbench
===================================

# mod8_seq_checker

Sequence checker for the receiving end of a free-running modulo-2^WIDTH count stream, such as the 3-bit mod-8 counter output. It samples the incoming count and locks once it sees a run of consecutive +1 increments. While locked, it flags every out-of-sequence value and keeps a saturating error tally. It sits on the consumer side of any counter-driven bus as a link/integrity monitor.

## Interface
- WIDTH, 3: count width; modulus is 2^WIDTH
- LOCK_CNT, 4: consecutive matching samples after the seed needed to lock (≥1)
- LOSS_CNT, 2: consecutive mismatches while locked needed to drop lock (≥1)
- ERR_W, 8: width of saturating error counter

- clk  in  1  sampling clock; all logic on posedge (upstream count launches on negedge, so data is stable here)
- rst  in  1  reset rst, synchronous, active-high
- valid  in  1  cnt_in qualifier; cycles with valid=0 are ignored
- cnt_in  in  WIDTH  observed count
- clr_err  in  1  synchronous clear of err_count
- locked  out  1  high while in LOCKED
- err  out  1  one-cycle pulse per mismatch while LOCKED
- err_count  out  ERR_W  saturating mismatch count
- expected  out  WIDTH  next value the checker expects
- wrap  out  1  only when MOD8_CHK_WRAP_EN is defined; see Configuration

## Operation
- States: HUNT, CONFIRM, LOCKED. Internal counters: good (0..LOCK_CNT) and bad (0..LOSS_CNT).
- HUNT: on valid, expected ← cnt_in+1, good ← 0, go to CONFIRM.
- CONFIRM: on valid with a match (cnt_in==expected), expected ← expected+1 and good ← good+1. When good reaches LOCK_CNT, go to LOCKED with bad ← 0.
- CONFIRM, mismatch: reseed with expected ← cnt_in+1, good ← 0, stay in CONFIRM. err does not pulse outside LOCKED.
- LOCKED, match: expected ← expected+1, bad ← 0.
- LOCKED, mismatch (flywheel behaviour):
  - err pulses.
  - err_count increments, saturating.
  - expected ← expected+1, so a single glitch costs exactly one error.
  - bad ← bad+1.
  - When bad reaches LOSS_CNT: go to CONFIRM seeded with expected ← cnt_in+1, good ← 0.
- valid=0: state, expected, good and bad all hold. err stays 0.
- Arithmetic is modulo 2^WIDTH, so 2^WIDTH−1 → 0 is a match.
- err_count:
  - Saturates at 2^ERR_W−1.
  - clr_err zeroes it.
  - clr_err together with an error gives 1 (clear, then count).
- An upstream counter held in reset (repeated 0) reads as mismatches and drops lock after LOSS_CNT samples.

## Timing
- All outputs are registered.
- Reset values: state HUNT, locked 0, err 0, err_count 0, expected 0, wrap 0, good 0, bad 0.
- rst asserted mid-operation forces these values at the next edge, overriding all other inputs.
- locked rises in the cycle after the edge that samples the LOCK_CNT-th match.
- Minimum lock latency: LOCK_CNT+1 valid samples (seed plus LOCK_CNT matches).
- err and the err_count update are visible in the cycle after the mismatching sample's edge.
- locked falls in the cycle after the LOSS_CNT-th consecutive mismatch. err still pulses for that sample.
- Throughput: one sample per clock. No backpressure.

## Configuration
- MOD8_CHK_WRAP_EN defined:
  - wrap port exists.
  - wrap pulses for one cycle after any matching valid sample with cnt_in==0 while LOCKED (wrap-around detected).
  - Reset value is 0.
- MOD8_CHK_WRAP_EN undefined: no wrap port and no associated logic. All other behaviour is identical.

## Structure
- Package mod8_chk_pkg:
  - state enum typedef (HUNT, CONFIRM, LOCKED)
  - default constants for WIDTH, LOCK_CNT, LOSS_CNT, ERR_W
- Sub-module sat_counter (parameter W; inputs inc and clr, output cnt): implements err_count with the clear-then-count rule.
- FSM, match compare, good/bad tracking and expected register live in mod8_seq_checker.

## Test plan
- Lock acquisition: rst, then valid stream 3,4,5,6,7 (defaults) → locked=1 in the cycle after sample 7; err never pulses; expected=0.
- Wrap-around: locked stream …6,7,0,1 → no err. With MOD8_CHK_WRAP_EN, exactly one wrap pulse, after sample 0.
- Single glitch: locked stream 2,3,6,5,6 → one err pulse, on sample 6; err_count=1; locked stays 1; expected=7 after the last sample.
- Upstream reset: locked at expected=4, stream 0,0,0,1,2,3,4,5 → err pulses on the first two 0s and locked drops. Relock: locked=1 after sample 5.
- Saturation and clear: ERR_W=2, locked, 5 isolated glitches → err_count=3. clr_err asserted with a glitch → err_count=1.
- Reset and gaps: valid=0 gaps inside a locked stream → lock is held and expected is frozen. rst while locked → all outputs 0 next cycle, state HUNT.

Source files
------------

// File: rtl/mod8_chk_pkg.sv
// Shared types and default sizing for the modulo count-stream sequence checker.
package mod8_chk_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 3;
    localparam int DEF_LOCK_CNT = 4;
    localparam int DEF_LOSS_CNT = 2;
    localparam int DEF_ERR_W    = 8;

endpackage

// File: rtl/mod8_seq_checker_sat_counter.sv
// Saturating event counter; a clear in the same cycle as an event yields one.
module sat_counter
    import mod8_chk_pkg::*;
#(
    parameter int W = DEF_ERR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear first, then count on top of the cleared value.
    always_comb begin
        cnt_d = clr ? '0 : cnt_q;
        if (inc && (cnt_d != {W{1'b1}})) begin
            cnt_d = cnt_d + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mod8_seq_checker.sv
// Lock/flywheel sequence checker for a free-running modulo-2^WIDTH count stream.
// Optional wrap-around pulse output is built only when MOD8_CHK_WRAP_EN is defined.
module mod8_seq_checker
    import mod8_chk_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int LOSS_CNT = DEF_LOSS_CNT,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
`ifdef MOD8_CHK_WRAP_EN
    ,
    output logic             wrap
`endif
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    state_t           state_q;
    logic [WIDTH-1:0] expected_q;
    logic [GW-1:0]    good_q;
    logic [BW-1:0]    bad_q;
    logic             locked_q;
    logic             err_q;

    logic             match;
    logic             mis_lock;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] exp_next;

    assign match    = (cnt_in == expected_q);
    assign mis_lock = valid && (state_q == LOCKED) && !match;
    assign seed     = cnt_in + WIDTH'(1);
    assign exp_next = expected_q + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            expected_q <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= mis_lock;
            if (valid) begin
                unique case (state_q)
                    HUNT: begin
                        expected_q <= seed;
                        good_q     <= '0;
                        state_q    <= CONFIRM;
                    end
                    CONFIRM: begin
                        if (match) begin
                            expected_q <= exp_next;
                            good_q     <= good_q + GW'(1);
                            if (good_q + GW'(1) == GW'(LOCK_CNT)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                bad_q    <= '0;
                            end
                        end else begin
                            expected_q <= seed;
                            good_q     <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            expected_q <= exp_next;
                            bad_q      <= '0;
                        end else if (bad_q + BW'(1) == BW'(LOSS_CNT)) begin
                            // Sustained loss: fall back and reseed from the live stream.
                            state_q    <= CONFIRM;
                            locked_q   <= 1'b0;
                            expected_q <= seed;
                            good_q     <= '0;
                            bad_q      <= bad_q + BW'(1);
                        end else begin
                            expected_q <= exp_next;
                            bad_q      <= bad_q + BW'(1);
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MOD8_CHK_WRAP_EN
    logic wrap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= valid && (state_q == LOCKED) && match && (cnt_in == '0);
        end
    end

    assign wrap = wrap_q;
`endif

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (mis_lock),
        .clr (clr_err),
        .cnt (err_count)
    );

    assign locked   = locked_q;
    assign err      = err_q;
    assign expected = expected_q;

endmodule

// File: tb/tb_mod8_seq_checker.sv
// Scoreboard bench for mod8_seq_checker: default instance plus an ERR_W=2 instance on shared stimulus.
module tb_mod8_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [2:0] cnt_in = 3'd0;
    logic       clr_err = 1'b0;

    logic       locked, err, locked2, err2;
    logic [7:0] err_count;
    logic [1:0] err_count2;
    logic [2:0] expected, expected2;
    logic       wrap_o, wrap2;

    always #5 clk = ~clk;

    mod8_seq_checker dut (
        .clk(clk), .rst(rst), .valid(valid), .cnt_in(cnt_in), .clr_err(clr_err),
        .locked(locked), .err(err), .err_count(err_count), .expected(expected)
`ifdef MOD8_CHK_WRAP_EN
        , .wrap(wrap_o)
`endif
    );

    mod8_seq_checker #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .valid(valid), .cnt_in(cnt_in), .clr_err(clr_err),
        .locked(locked2), .err(err2), .err_count(err_count2), .expected(expected2)
`ifdef MOD8_CHK_WRAP_EN
        , .wrap(wrap2)
`endif
    );

`ifdef MOD8_CHK_WRAP_EN
    localparam int WRAP_EXP = 2;
`else
    assign wrap_o = 1'b0;
    assign wrap2  = 1'b0;
    localparam int WRAP_EXP = 0;
`endif

    typedef struct packed {
        logic       lk;
        logic       lk2;
        logic       er;
        logic [7:0] ec8;
        logic [1:0] ec2;
        logic [2:0] ex;
        logic       wr;
    } obs_t;

    obs_t obs;
    assign obs = '{lk: locked, lk2: locked2, er: err, ec8: err_count, ec2: err_count2,
                   ex: expected, wr: wrap_o};

    obs_t sb[$];
    obs_t e;
    int total = 0;
    int bad = 0;

    // Reference model state: 0 = hunt, 1 = confirm, 2 = locked
    int       m_state = 0;
    logic [2:0] m_exp = 3'd0;
    int       m_good = 0;
    int       m_bad = 0;
    int       m_ec8 = 0;
    int       m_ec2 = 0;

    task automatic drive(input logic v, input logic [2:0] c, input logic clr, input logic r);
        obs_t x;
        logic hit, e_err, e_wrap;
        @(negedge clk);
        valid = v; cnt_in = c; clr_err = clr; rst = r;
        e_err = 1'b0;
        e_wrap = 1'b0;
        if (r) begin
            m_state = 0; m_exp = 3'd0; m_good = 0; m_bad = 0; m_ec8 = 0; m_ec2 = 0;
        end else begin
            if (v) begin
                hit = (c == m_exp);
                if (m_state == 0) begin
                    m_exp = c + 3'd1; m_good = 0; m_state = 1;
                end else if (m_state == 1) begin
                    if (hit) begin
                        m_exp = m_exp + 3'd1; m_good++;
                        if (m_good == 4) begin m_state = 2; m_bad = 0; end
                    end else begin
                        m_exp = c + 3'd1; m_good = 0;
                    end
                end else begin
                    if (hit) begin
                        m_exp = m_exp + 3'd1; m_bad = 0;
                        if (c == 3'd0) e_wrap = 1'b1;
                    end else begin
                        e_err = 1'b1; m_exp = m_exp + 3'd1; m_bad++;
                        if (m_bad == 2) begin m_state = 1; m_exp = c + 3'd1; m_good = 0; end
                    end
                end
            end
            if (clr) begin m_ec8 = 0; m_ec2 = 0; end
            if (e_err) begin
                if (m_ec8 < 255) m_ec8++;
                if (m_ec2 < 3) m_ec2++;
            end
        end
`ifndef MOD8_CHK_WRAP_EN
        e_wrap = 1'b0;
`endif
        x.lk = (m_state == 2); x.lk2 = (m_state == 2); x.er = e_err;
        x.ec8 = 8'(m_ec8); x.ec2 = 2'(m_ec2); x.ex = m_exp; x.wr = e_wrap;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 3'd5, 1'b0, 1'b1);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL reset_sb[%0d]: got %h want %h", i, obs, e); end
        end
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_zero: got %h want 0", obs); end
    endtask

    task automatic test_lock();
        logic [2:0] s [5] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, s[i], 1'b0, 1'b0);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL lock_sb[%0d]: got %h want %h", i, obs, e); end
            total++;
            if (err !== 1'b0) begin bad++; $display("FAIL lock_err[%0d]: got %b want 0", i, err); end
            if (i == 3) begin
                total++;
                if (locked !== 1'b0) begin bad++; $display("FAIL lock_early: got %b want 0", locked); end
            end
        end
        total++;
        if (locked !== 1'b1 || expected !== 3'd0) begin
            bad++; $display("FAIL lock_done: got locked=%b exp=%0d want locked=1 exp=0", locked, expected);
        end
    endtask

    task automatic test_wrap();
        int wraps = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'(i), 1'b0, 1'b0);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL wrap_sb[%0d]: got %h want %h", i, obs, e); end
            if (err !== 1'b0) begin
                total++; bad++; $display("FAIL wrap_err[%0d]: got %b want 0", i, err);
            end
            if (wrap_o === 1'b1) wraps++;
        end
        total++;
        if (wraps !== WRAP_EXP) begin bad++; $display("FAIL wrap_count: got %0d want %0d", wraps, WRAP_EXP); end
    endtask

    task automatic test_glitch();
        logic [2:0] s [5] = '{3'd2, 3'd3, 3'd6, 3'd5, 3'd6};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, s[i], 1'b0, 1'b0);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL glitch_sb[%0d]: got %h want %h", i, obs, e); end
            total++;
            if (err !== (i == 2)) begin bad++; $display("FAIL glitch_err[%0d]: got %b want %b", i, err, (i == 2)); end
        end
        total++;
        if (err_count !== 8'd1 || locked !== 1'b1 || expected !== 3'd7) begin
            bad++;
            $display("FAIL glitch_end: got cnt=%0d locked=%b exp=%0d want cnt=1 locked=1 exp=7",
                     err_count, locked, expected);
        end
    endtask

    task automatic test_upstream_reset();
        logic [2:0] s [13] = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3,
                               3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, s[i], 1'b0, 1'b0);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL upreset_sb[%0d]: got %h want %h", i, obs, e); end
            if (i == 4) begin
                total++;
                if (expected !== 3'd4 || locked !== 1'b1) begin
                    bad++; $display("FAIL upreset_pre: got exp=%0d locked=%b want 4/1", expected, locked);
                end
            end
            if (i >= 5) begin
                total++;
                if (err !== (i == 5 || i == 6)) begin
                    bad++; $display("FAIL upreset_err[%0d]: got %b want %b", i, err, (i == 5 || i == 6));
                end
            end
            if (i == 6) begin
                total++;
                if (locked !== 1'b0) begin bad++; $display("FAIL upreset_drop: got %b want 0", locked); end
            end
        end
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL upreset_relock: got %b want 1", locked); end
    endtask

    task automatic test_saturation();
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        e = sb.pop_front();
        total++;
        if (obs !== e || err_count !== 8'd0) begin bad++; $display("FAIL sat_clr: got %h want %h", obs, e); end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, (i % 2 == 0) ? (m_exp ^ 3'd4) : m_exp, 1'b0, 1'b0);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL sat_sb[%0d]: got %h want %h", i, obs, e); end
        end
        total++;
        if (err_count2 !== 2'd3 || err_count !== 8'd5 || locked !== 1'b1) begin
            bad++; $display("FAIL sat_value: got w2=%0d w8=%0d locked=%b want 3/5/1", err_count2, err_count, locked);
        end
        drive(1'b1, m_exp ^ 3'd4, 1'b1, 1'b0);
        e = sb.pop_front();
        total++;
        if (obs !== e || err_count2 !== 2'd1 || err_count !== 8'd1) begin
            bad++; $display("FAIL sat_clr_err: got %h want %h", obs, e);
        end
    endtask

    task automatic test_gaps_and_reset();
        logic [2:0] held;
        held = expected;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, (i % 2 == 0) ? held : (held ^ 3'd5), 1'b0, 1'b0);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL gap_sb[%0d]: got %h want %h", i, obs, e); end
            total++;
            if (expected !== held || locked !== 1'b1 || err !== 1'b0) begin
                bad++; $display("FAIL gap_hold[%0d]: got exp=%0d locked=%b err=%b want %0d/1/0",
                                i, expected, locked, err, held);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, m_exp, 1'b0, 1'b0);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL gap_resume[%0d]: got %h want %h", i, obs, e); end
        end
        drive(1'b1, m_exp ^ 3'd2, 1'b1, 1'b1);
        e = sb.pop_front();
        total++;
        if (obs !== e || obs !== '0) begin bad++; $display("FAIL rst_locked: got %h want 0", obs); end
        drive(1'b1, 3'd6, 1'b0, 1'b0);
        e = sb.pop_front();
        total++;
        if (obs !== e || locked !== 1'b0 || expected !== 3'd7) begin
            bad++; $display("FAIL rst_hunt_seed: got %h want %h", obs, e);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_glitch();
        test_upstream_reset();
        test_saturation();
        test_gaps_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
